// File: rtl/xeng_mac_sequencer.sv
// Control sequencer for one dsp48e_mac_chain: groups valid samples into windows,
// drives the chain clock-enable / accumulator-load and flags completed sums.
module xeng_mac_sequencer #(
    parameter int ACC_LEN_BITS = 16,
    parameter int MAC_LATENCY  = 4,
    parameter int CNT_BITS     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync,
    input  logic [ACC_LEN_BITS-1:0] acc_len,
    input  logic                    din_valid,
    output logic                    mac_ce,
    output logic                    mac_load,
    output logic                    dout_valid,
    output logic [CNT_BITS-1:0]     acc_cnt,
    output logic                    busy,
    output logic                    sync_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_sync_acc;

    logic [ACC_LEN_BITS-1:0] r_len;
    logic [ACC_LEN_BITS-1:0] r_cnt;
    logic [ACC_LEN_BITS-1:0] w_len;
    logic [ACC_LEN_BITS-1:0] w_cnt;
    logic [ACC_LEN_BITS-1:0] w_cnt_nxt;
    logic                    w_take;
    logic                    w_last;
    logic                    w_marker;
    logic                    w_err_set;

    logic                    r_mac_ce;
    logic                    r_mac_load;
    logic [MAC_LATENCY:0]    r_dly;
    logic [CNT_BITS-1:0]     r_acc_cnt;
    logic                    r_sync_err;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave a value held (which infers a latch).
    always_comb begin
        w_state_nxt = r_state;
        w_sync_acc  = 1'b0;
        if (!en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_ARMED;
                S_ARMED: begin
                    if (sync) begin
                        w_state_nxt = S_ACCUM;
                        w_sync_acc  = 1'b1;
                    end
                end
                S_ACCUM: w_sync_acc = sync;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // An accepted sync restarts the window on its own cycle, so its din_valid counts.
    always_comb begin
        w_len     = r_len;
        w_cnt     = r_cnt;
        w_cnt_nxt = r_cnt;
        if (w_sync_acc) begin
            w_len = (acc_len == '0) ? ACC_LEN_BITS'(1) : acc_len;
            w_cnt = '0;
        end
        w_take    = en && din_valid && (w_sync_acc || (r_state == S_ACCUM));
        w_last    = (w_cnt == w_len - ACC_LEN_BITS'(1));
        w_marker  = w_take && w_last;
        w_err_set = w_sync_acc && (r_state == S_ACCUM) && (r_cnt != '0);
        if (!en) begin
            w_cnt_nxt = '0;
        end else if (w_take) begin
            w_cnt_nxt = w_last ? '0 : w_cnt + ACC_LEN_BITS'(1);
        end else begin
            w_cnt_nxt = w_cnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= ACC_LEN_BITS'(1);
            r_cnt      <= '0;
            r_mac_ce   <= 1'b0;
            r_mac_load <= 1'b0;
            r_dly      <= '0;
            r_acc_cnt  <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len;
            r_cnt      <= w_cnt_nxt;
            r_mac_ce   <= w_take;
            r_mac_load <= w_take && (w_cnt == '0);
            if (!en) begin
                r_dly      <= '0;
                r_acc_cnt  <= '0;
                r_sync_err <= 1'b0;
            end else begin
                r_dly <= {r_dly[MAC_LATENCY-1:0], w_marker};
                // Count on the edge that raises dout_valid.
                if (r_dly[MAC_LATENCY-1]) begin
                    r_acc_cnt <= r_acc_cnt + CNT_BITS'(1);
                end
                if (w_err_set) begin
                    r_sync_err <= 1'b1;
                end
            end
        end
    end

    assign mac_ce     = r_mac_ce;
    assign mac_load   = r_mac_load;
    assign dout_valid = r_dly[MAC_LATENCY];
    assign acc_cnt    = r_acc_cnt;
    assign busy       = (r_state == S_ACCUM);
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_xeng_mac_sequencer.sv
// Self-checking bench for xeng_mac_sequencer: directed vector table, hand-written
// corner sequences and random traces against a trace-level reference model.
module tb_xeng_mac_sequencer;

    localparam int ALB = 16;
    localparam int LAT = 4;
    localparam int CB  = 4;
    localparam int N   = 200;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           sync = 1'b0;
    logic           din_valid = 1'b0;
    logic [ALB-1:0] acc_len = '0;
    logic           mac_ce, mac_load, dout_valid, busy, sync_err;
    logic [CB-1:0]  acc_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    xeng_mac_sequencer #(
        .ACC_LEN_BITS (ALB),
        .MAC_LATENCY  (LAT),
        .CNT_BITS     (CB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync       (sync),
        .acc_len    (acc_len),
        .din_valid  (din_valid),
        .mac_ce     (mac_ce),
        .mac_load   (mac_load),
        .dout_valid (dout_valid),
        .acc_cnt    (acc_cnt),
        .busy       (busy),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Per-cycle input trace, observed outputs and model expectations.
    logic           t_en[N], t_sync[N], t_dv[N];
    logic [ALB-1:0] t_len[N];
    logic           a_ce[N], a_load[N], a_dv[N], a_busy[N], a_err[N];
    logic [CB-1:0]  a_cnt[N];
    logic           e_ce[N], e_load[N], e_dv[N], e_busy[N], e_err[N];
    logic [CB-1:0]  e_cnt[N];

    typedef struct {
        logic [ALB-1:0] len;
        int             step;
        int             nsamp;
        int             exp_pulses;
        int             exp_first;
        int             exp_loads;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_trace();
        for (int c = 0; c < N; c++) begin
            t_en[c] = 1'b0; t_sync[c] = 1'b0; t_dv[c] = 1'b0; t_len[c] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; din_valid = 1'b0; acc_len = '0;
        step();
        rst_n = 1'b1;
    endtask

    // Trace cycle 0 is the first cycle after reset release.
    task automatic run_trace(input int n);
        do_reset();
        for (int c = 0; c < n; c++) begin
            en = t_en[c]; sync = t_sync[c]; acc_len = t_len[c]; din_valid = t_dv[c];
            @(negedge clk);
            a_ce[c] = mac_ce; a_load[c] = mac_load; a_dv[c] = dout_valid;
            a_busy[c] = busy; a_err[c] = sync_err; a_cnt[c] = acc_cnt;
            step();
        end
        en = 1'b0; sync = 1'b0; din_valid = 1'b0;
    endtask

    // Reference: walk the trace counting samples per window, then place each
    // window's result 1+LAT cycles after its last sample unless en dropped in between.
    task automatic model(input int n);
        int  mode;
        int  len;
        int  pos;
        int  running;
        int  d;
        bit  killed;
        logic err;
        int  last_q[$];
        mode = 0; len = 1; pos = 0; err = 1'b0; running = 0;
        for (int c = 0; c < n; c++) begin
            e_ce[c] = 1'b0; e_load[c] = 1'b0; e_dv[c] = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            e_busy[c] = (mode == 2);
            e_err[c]  = err;
            if (!t_en[c]) begin
                mode = 0; pos = 0; err = 1'b0;
            end else begin
                if (t_sync[c] && mode != 0) begin
                    if (mode == 2 && pos != 0) err = 1'b1;
                    len  = (t_len[c] == '0) ? 1 : int'(t_len[c]);
                    pos  = 0;
                    mode = 2;
                end else if (mode == 0) begin
                    mode = 1;
                end
                if (t_dv[c] && mode == 2) begin
                    if (c + 1 < n) begin
                        e_ce[c+1]   = 1'b1;
                        e_load[c+1] = (pos == 0);
                    end
                    pos++;
                    if (pos == len) begin
                        pos = 0;
                        last_q.push_back(c);
                    end
                end
            end
        end
        foreach (last_q[i]) begin
            d = last_q[i] + 1 + LAT;
            killed = 1'b0;
            for (int u = last_q[i] + 1; u < d && u < n; u++) begin
                if (!t_en[u]) killed = 1'b1;
            end
            if (!killed && d < n) e_dv[d] = 1'b1;
        end
        for (int c = 0; c < n; c++) begin
            if (c > 0 && !t_en[c-1]) running = 0;
            if (e_dv[c]) running++;
            e_cnt[c] = CB'(running);
        end
    endtask

    task automatic compare_trace(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s cyc%0d {ce,load,dv,busy,err,cnt}", name, c),
                  {23'd0, a_ce[c], a_load[c] & a_ce[c], a_dv[c], a_busy[c], a_err[c], a_cnt[c]},
                  {23'd0, e_ce[c], e_load[c], e_dv[c], e_busy[c], e_err[c], e_cnt[c]});
        end
    endtask

    function automatic int count_dv(input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) s += int'(a_dv[c]);
        return s;
    endfunction

    function automatic int count_ce(input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) s += int'(a_ce[c]);
        return s;
    endfunction

    function automatic int count_load(input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) s += int'(a_ce[c] & a_load[c]);
        return s;
    endfunction

    function automatic int first_dv(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (a_dv[c]) return c;
        return -1;
    endfunction

    initial begin
        // {acc_len, step, samples, pulses, first dout_valid (rel. to sync), loads}
        vecs[0] = '{16'd8, 1, 17,  2, 12, 3};
        vecs[1] = '{16'd4, 2,  9,  2, 11, 3};
        vecs[2] = '{16'd0, 1,  6,  6,  5, 6};
        vecs[3] = '{16'd1, 3,  4,  4,  5, 4};
        vecs[4] = '{16'd3, 1,  2,  0, -1, 1};
        vecs[5] = '{16'd1, 1, 20, 20,  5, 20};

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset outputs", {23'd0, mac_ce, mac_load, dout_valid, busy, sync_err, acc_cnt}, 32'd0);
        step();

        // Vector table: arm at cycle 0, sync at cycle 1 (relative cycle 0)
        for (int v = 0; v < 6; v++) begin
            int f;
            clear_trace();
            for (int c = 0; c < 45; c++) t_en[c] = 1'b1;
            t_sync[1] = 1'b1;
            t_len[1]  = vecs[v].len;
            for (int k = 0; k < vecs[v].nsamp; k++) t_dv[1 + k * vecs[v].step] = 1'b1;
            run_trace(45);
            f = first_dv(0, 44);
            check($sformatf("vec%0d pulses", v), count_dv(0, 44), vecs[v].exp_pulses);
            check($sformatf("vec%0d first_dv", v), (f < 0) ? -1 : f - 1, vecs[v].exp_first);
            check($sformatf("vec%0d loads", v), count_load(0, 44), vecs[v].exp_loads);
            check($sformatf("vec%0d ce_count", v), count_ce(0, 44), vecs[v].nsamp);
            check($sformatf("vec%0d acc_cnt", v), a_cnt[44], vecs[v].exp_pulses % (1 << CB));
            model(45);
            compare_trace($sformatf("vec%0d", v), 45);
        end

        // Mid-window sync: len 8, re-sync at sample 3 with len 2
        clear_trace();
        for (int c = 0; c < 30; c++) t_en[c] = 1'b1;
        t_sync[1] = 1'b1; t_len[1] = 16'd8;
        t_sync[4] = 1'b1; t_len[4] = 16'd2;
        for (int c = 1; c <= 11; c++) t_dv[c] = 1'b1;
        run_trace(30);
        check("midsync err before", a_err[4], 1'b0);
        check("midsync err after", a_err[5], 1'b1);
        check("midsync first_dv", first_dv(0, 29) - 1, 9);
        check("midsync pulses", count_dv(0, 29), 4);
        model(30);
        compare_trace("midsync", 30);

        // Sync on a window boundary restarts silently
        clear_trace();
        for (int c = 0; c < 20; c++) t_en[c] = 1'b1;
        t_sync[1] = 1'b1; t_len[1] = 16'd2;
        t_sync[3] = 1'b1; t_len[3] = 16'd2;
        for (int c = 1; c <= 6; c++) t_dv[c] = 1'b1;
        run_trace(20);
        check("silent sync err", a_err[19], 1'b0);
        check("silent sync pulses", count_dv(0, 19), 3);

        // en drop with two markers in flight
        clear_trace();
        for (int c = 0; c < 30; c++) t_en[c] = 1'b1;
        t_en[9] = 1'b0;
        t_sync[1] = 1'b1; t_len[1] = 16'd2;
        for (int c = 1; c <= 8; c++) t_dv[c] = 1'b1;
        for (int c = 10; c <= 21; c++) t_dv[c] = 1'b1;
        t_sync[21] = 1'b1; t_len[21] = 16'd1;
        run_trace(30);
        check("endrop acc_cnt before", a_cnt[9], 2);
        check("endrop acc_cnt after", a_cnt[10], 0);
        check("endrop no dout", count_dv(10, 20), 0);
        check("endrop busy before", a_busy[9], 1'b1);
        check("endrop busy after", a_busy[10], 1'b0);
        check("endrop ignored din", count_ce(10, 21), 0);
        check("endrop rearm ce", a_ce[22], 1'b1);
        check("endrop rearm busy", a_busy[22], 1'b1);
        model(30);
        compare_trace("endrop", 30);

        // Async reset between clock edges mid-window
        do_reset();
        en = 1'b1;
        step();
        sync = 1'b1; acc_len = 16'd3; din_valid = 1'b1;
        step();
        step();
        sync = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("pre-reset ce", mac_ce, 1'b1);
        check("pre-reset err", sync_err, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {23'd0, mac_ce, mac_load, dout_valid, busy, sync_err, acc_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        begin
            int ce_seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                ce_seen += int'(mac_ce) + int'(busy);
                step();
            end
            check("post-reset needs sync", ce_seen, 0);
        end
        en = 1'b0; din_valid = 1'b0;

        // Random traces against the model
        for (int r = 0; r < 6; r++) begin
            clear_trace();
            for (int c = 0; c < 150; c++) begin
                t_en[c]   = ($urandom_range(0, 29) != 0);
                t_sync[c] = ($urandom_range(0, 11) == 0);
                t_len[c]  = (r == 5) ? ALB'($urandom_range(0, 12)) : ALB'($urandom_range(0, 5));
                t_dv[c]   = ($urandom_range(0, 9) < 7);
            end
            run_trace(150);
            model(150);
            compare_trace($sformatf("rand%0d", r), 150);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
